// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, owns the
// program counter, and feeds the IF/ID register. A one-entry skid buffer
// catches a response that arrives while decode is stalling. Taken branches
// can land while a fetch is still outstanding; the SQUASH state then
// discards the stale response. An opcode-zero instruction halts fetching
// until the next redirect.
//
//   state  | meaning
//   RUN    | normal fetching; request issued while the skid buffer is empty
//   SQUASH | redirected mid-fetch; waiting to drop the stale response
//   HALT   | halt instruction reached IF/ID; fetch frozen until redirect
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_f,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic        imemDone,
  input  logic [15:0] imemData,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  output logic [15:0] Inst,
  output logic [15:0] PCPlus2,
  output logic        InstValid,
  output logic        err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] skid_inst;
  logic [15:0] skid_pc2;
  logic        skid_valid;
  logic        accept;
  logic [15:0] pc_inc;

  // Request is gated by reset directly so it drops the moment reset asserts.
  assign imemRd   = (state == RUN) && !skid_valid && !rst;
  assign imemAddr = pc;
  assign accept   = imemDone && imemRd;
  assign pc_inc   = pc + 16'd2;

  function automatic logic is_halt(input logic [15:0] inst);
    return inst[15:11] == 5'b00000;
  endfunction

  // Fetch state machine, pc, skid buffer and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      skid_inst  <= NOP_INST;
      skid_pc2   <= 16'h0000;
      skid_valid <= 1'b0;
      Inst       <= NOP_INST;
      PCPlus2    <= 16'h0000;
      InstValid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      // A response nobody asked for is flagged and otherwise ignored; in
      // SQUASH the response is expected and silently dropped.
      err <= imemDone && !imemRd && (state != SQUASH);

      if (redirect) begin
        pc         <= redirectPC;
        skid_valid <= 1'b0;
        Inst       <= NOP_INST;
        InstValid  <= 1'b0;
        case (state)
          RUN:     state <= (imemRd && !imemDone) ? SQUASH : RUN;
          SQUASH:  state <= imemDone ? RUN : SQUASH;
          default: state <= RUN;
        endcase
      end else begin
        case (state)
          RUN: begin
            if (hazard_f) begin
              if (accept) begin
                skid_inst  <= imemData;
                skid_pc2   <= pc_inc;
                skid_valid <= 1'b1;
                pc         <= pc_inc;
              end
            end else if (skid_valid) begin
              Inst       <= skid_inst;
              PCPlus2    <= skid_pc2;
              InstValid  <= 1'b1;
              skid_valid <= 1'b0;
              if (is_halt(skid_inst)) state <= HALT;
            end else if (accept) begin
              Inst      <= imemData;
              PCPlus2   <= pc_inc;
              InstValid <= 1'b1;
              pc        <= pc_inc;
              if (is_halt(imemData)) state <= HALT;
            end else begin
              Inst      <= NOP_INST;
              InstValid <= 1'b0;
            end
          end
          SQUASH: begin
            if (imemDone) state <= RUN;
            if (!hazard_f) begin
              Inst      <= NOP_INST;
              InstValid <= 1'b0;
            end
          end
          HALT: begin
            // Everything frozen until a redirect.
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule
